// File: rtl/sram_arb_bridge_pkg.sv
// Shared constants for the SRAM arbitration bridge: FSM state encoding,
// port-select codes, strobe width and the width of the packed shared-port bus.
package sram_arb_bridge_pkg;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Which request buffer currently owns the shared port
    localparam logic PORT_INST = 1'b0;
    localparam logic PORT_DATA = 1'b1;

    // Byte-strobe width seen on the core and memory sides
    localparam int STRB_W = 4;

    // Width of {mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata}
    function automatic int mem_req_wd(input int addr_w, input int data_w);
        return 1 + 1 + STRB_W + addr_w + data_w;
    endfunction

endpackage

// File: rtl/sram_req_buf.sv
// One per core port: holds the latched request (addr, wen, wdata), its pending
// flag, and the read-data register returned to the core.
module sram_req_buf #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   capture,
    input  logic                                   en,
    input  logic [sram_arb_bridge_pkg::STRB_W-1:0] wen,
    input  logic [ADDR_W-1:0]                      addr,
    input  logic [DATA_W-1:0]                      wdata,
    input  logic                                   retire,
    input  logic [DATA_W-1:0]                      mem_rdata,
    output logic                                   pending,
    output logic [sram_arb_bridge_pkg::STRB_W-1:0] wen_q,
    output logic [ADDR_W-1:0]                      addr_q,
    output logic [DATA_W-1:0]                      wdata_q,
    output logic [DATA_W-1:0]                      rdata
);
    import sram_arb_bridge_pkg::*;

    logic rdata_load;

    // Only a completed read updates the data returned to the core
    assign rdata_load = retire && (wen_q == '0);

    // Latch the core request and track whether it still needs the shared port
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!rst) begin
            // NOTE: the request copies are reset too so the shared-port fields
            // read 0 after reset instead of stale addresses or data.
            pending <= 1'b0;
            wen_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (capture && en) begin
            pending <= 1'b1;
            wen_q   <= wen;
            addr_q  <= addr;
            wdata_q <= wdata;
        end else if (retire) begin
            pending <= 1'b0;
        end
    end

    // Read-data register: holds until this port's next completed read
    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata <= '0;
        end else if (rdata_load) begin
            rdata <= mem_rdata;
        end
    end

endmodule

// File: rtl/sram_arb_bridge.sv
// Merges the core's inst_sram_* and data_sram_* ports onto a single memory
// port with a req/addr_ok/data_ok handshake, one transaction at a time, and
// stalls the core until every accepted request has completed.
// Optional build macro BRIDGE_STALL_CNT_EN adds a 32-bit stall_cycles counter.
module sram_arb_bridge #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int DATA_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_en,
    input  logic [3:0]        inst_wen,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic [DATA_W-1:0] inst_wdata,
    output logic [DATA_W-1:0] inst_rdata,
    input  logic              data_en,
    input  logic [3:0]        data_wen,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic [DATA_W-1:0] data_rdata,
    output logic              stallreq,
`ifdef BRIDGE_STALL_CNT_EN
    output logic [31:0]       stall_cycles,
`endif
    output logic              mem_req,
    output logic              mem_wr,
    output logic [3:0]        mem_wstrb,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_addr_ok,
    input  logic              mem_data_ok,
    input  logic [DATA_W-1:0] mem_rdata
);
    import sram_arb_bridge_pkg::*;

    localparam int REQ_WD = mem_req_wd(ADDR_W, DATA_W);

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic              any_en;
    logic              capture;
    logic              sel;
    logic              other_pend;
    logic              txn_done;
    logic              inst_retire;
    logic              data_retire;
    logic              inst_pend;
    logic              data_pend;
    logic [3:0]        inst_wen_q;
    logic [3:0]        data_wen_q;
    logic [ADDR_W-1:0] inst_addr_q;
    logic [ADDR_W-1:0] data_addr_q;
    logic [DATA_W-1:0] inst_wdata_q;
    logic [DATA_W-1:0] data_wdata_q;
    logic [REQ_WD-1:0] mem_bus;

    assign any_en  = inst_en | data_en;
    assign capture = (state == ST_IDLE);

    // A transaction completes on data_ok in WAIT, or on addr_ok+data_ok together in REQ
    assign txn_done    = ((state == ST_REQ) && mem_addr_ok && mem_data_ok) ||
                         ((state == ST_WAIT) && mem_data_ok);
    assign inst_retire = txn_done && (sel == PORT_INST);
    assign data_retire = txn_done && (sel == PORT_DATA);

    sram_req_buf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_inst_buf (
        .clk       (clk),
        .rst       (rst),
        .capture   (capture),
        .en        (inst_en),
        .wen       (inst_wen),
        .addr      (inst_addr),
        .wdata     (inst_wdata),
        .retire    (inst_retire),
        .mem_rdata (mem_rdata),
        .pending   (inst_pend),
        .wen_q     (inst_wen_q),
        .addr_q    (inst_addr_q),
        .wdata_q   (inst_wdata_q),
        .rdata     (inst_rdata)
    );

    sram_req_buf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_data_buf (
        .clk       (clk),
        .rst       (rst),
        .capture   (capture),
        .en        (data_en),
        .wen       (data_wen),
        .addr      (data_addr),
        .wdata     (data_wdata),
        .retire    (data_retire),
        .mem_rdata (mem_rdata),
        .pending   (data_pend),
        .wen_q     (data_wen_q),
        .addr_q    (data_addr_q),
        .wdata_q   (data_wdata_q),
        .rdata     (data_rdata)
    );

    // Port select: priority parameter breaks ties; pending flags stay constant
    // from REQ through the end of WAIT, so the choice is stable for the transaction
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        sel        = PORT_INST;
        other_pend = 1'b0;
        if (inst_pend && data_pend) begin
            sel = (DATA_FIRST != 0) ? PORT_DATA : PORT_INST;
        end else if (data_pend) begin
            sel = PORT_DATA;
        end
        other_pend = (sel == PORT_DATA) ? inst_pend : data_pend;
    end

    // Next-state logic; in IDLE the flags are set on the same edge as the
    // capture, so an asserted enable is what moves the FSM to REQ
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (any_en) state_nxt = ST_REQ;
            ST_REQ: begin
                if (mem_addr_ok) begin
                    if (mem_data_ok) state_nxt = other_pend ? ST_REQ : ST_DONE;
                    else             state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: if (mem_data_ok) state_nxt = other_pend ? ST_REQ : ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    // Shared-port drive: selected buffer while in REQ, all zero otherwise
    always_comb begin
        mem_bus = '0;
        if (state == ST_REQ) begin
            if (sel == PORT_DATA) mem_bus = {1'b1, |data_wen_q, data_wen_q, data_addr_q, data_wdata_q};
            else                  mem_bus = {1'b1, |inst_wen_q, inst_wen_q, inst_addr_q, inst_wdata_q};
        end
    end

    assign {mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata} = mem_bus;

    // Stall in the capture cycle and for as long as any transaction is in flight
    assign stallreq = ((state == ST_IDLE) && any_en) || (state == ST_REQ) || (state == ST_WAIT);

`ifdef BRIDGE_STALL_CNT_EN
    // Count stalled cycles; wraps naturally at 2^32
    always_ff @(posedge clk) begin
        if (!rst)          stall_cycles <= '0;
        else if (stallreq) stall_cycles <= stall_cycles + 32'd1;
    end
`endif

endmodule
